// File: rtl/hazard_ctrl.sv
// Hazard unit for the 5-stage MIPS pipeline: stall/flush, D/E forwarding selects, mult/div busy tracking; zero-cycle combinational outputs.
// A stall holds PC and IF/ID and bubbles ID/EX; optional stall counter enabled by HAZ_STALL_CNT_EN (tied to 0 otherwise).
module hazard_ctrl #(
    parameter int MULT_CYCLES = 5,
    parameter int DIV_CYCLES  = 10,
    parameter int CNT_W       = 32
) (
    input  logic             clk,
    input  logic             reset,
    input  logic [4:0]       rs_d,
    input  logic [4:0]       rt_d,
    input  logic [1:0]       tuse_rs_d,
    input  logic [1:0]       tuse_rt_d,
    input  logic             md_use_d,
    input  logic [4:0]       rs_e,
    input  logic [4:0]       rt_e,
    input  logic [4:0]       a3_e,
    input  logic [1:0]       tnew_e,
    input  logic             md_start_e,
    input  logic             md_div_e,
    input  logic [4:0]       a3_m,
    input  logic [1:0]       tnew_m,
    input  logic [4:0]       a3_w,
    output logic             pc_en,
    output logic             ifid_en,
    output logic             idex_flush,
    output logic [1:0]       fwd_rs_d,
    output logic [1:0]       fwd_rt_d,
    output logic [1:0]       fwd_rs_e,
    output logic [1:0]       fwd_rt_e,
    output logic             md_busy,
    output logic [CNT_W-1:0] stall_cnt
);

    localparam int MD_MAX = (MULT_CYCLES > DIV_CYCLES) ? MULT_CYCLES : DIV_CYCLES;
    localparam int MD_W   = (MD_MAX < 1) ? 1 : $clog2(MD_MAX + 1);

    logic [MD_W-1:0] md_cnt;
    logic            data_stall;
    logic            stall;

    function automatic logic src_stall(
        input logic [4:0] r,
        input logic [1:0] tuse,
        input logic [4:0] a3_e_i,
        input logic [1:0] tnew_e_i,
        input logic [4:0] a3_m_i,
        input logic [1:0] tnew_m_i
    );
        return (r != 5'd0) &&
               (((r == a3_e_i) && (tuse < tnew_e_i)) ||
                ((r == a3_m_i) && (tuse < tnew_m_i)));
    endfunction

    // An M match whose result is not yet ready falls through to W.
    function automatic logic [1:0] fwd_sel(
        input logic [4:0] r,
        input logic [4:0] a3_m_i,
        input logic [1:0] tnew_m_i,
        input logic [4:0] a3_w_i
    );
        if (r == 5'd0)
            return 2'b00;
        else if ((r == a3_m_i) && (tnew_m_i == 2'd0))
            return 2'b01;
        else if (r == a3_w_i)
            return 2'b10;
        else
            return 2'b00;
    endfunction

    always_ff @(posedge clk) begin
        if (reset)
            md_cnt <= '0;
        else if (md_start_e)
            md_cnt <= md_div_e ? MD_W'(DIV_CYCLES) : MD_W'(MULT_CYCLES);
        else if (md_cnt != '0)
            md_cnt <= md_cnt - MD_W'(1);
    end

    always_comb begin
        md_busy    = 1'b0;
        data_stall = 1'b0;
        stall      = 1'b0;
        pc_en      = 1'b1;
        ifid_en    = 1'b1;
        idex_flush = 1'b0;
        fwd_rs_d   = 2'b00;
        fwd_rt_d   = 2'b00;
        fwd_rs_e   = 2'b00;
        fwd_rt_e   = 2'b00;

        // md_cnt is being cleared in the reset cycle, so only a fresh start counts.
        md_busy    = md_start_e | (~reset & (md_cnt != '0));
        data_stall = src_stall(rs_d, tuse_rs_d, a3_e, tnew_e, a3_m, tnew_m) |
                     src_stall(rt_d, tuse_rt_d, a3_e, tnew_e, a3_m, tnew_m);
        stall      = data_stall | (md_use_d & md_busy);

        pc_en      = ~stall;
        ifid_en    = ~stall;
        idex_flush = stall;

        fwd_rs_d   = fwd_sel(rs_d, a3_m, tnew_m, a3_w);
        fwd_rt_d   = fwd_sel(rt_d, a3_m, tnew_m, a3_w);
        fwd_rs_e   = fwd_sel(rs_e, a3_m, tnew_m, a3_w);
        fwd_rt_e   = fwd_sel(rt_e, a3_m, tnew_m, a3_w);
    end

`ifdef HAZ_STALL_CNT_EN
    always_ff @(posedge clk) begin
        if (reset)
            stall_cnt <= '0;
        else if (stall && (stall_cnt != {CNT_W{1'b1}}))
            stall_cnt <= stall_cnt + CNT_W'(1);
    end
`else
    assign stall_cnt = '0;
`endif

endmodule

// File: doc/hazard_ctrl.md
Name: hazard_ctrl

Overview:
- Central pipeline scheduler for the 5-stage MIPS core.
- Drives the stall enables of the PC and IF/ID registers, the flush of the ID/EX register, and the 2-bit selects of the 3:1 forwarding muxes in the D and E stages.
- Owns a busy countdown for the multi-cycle mult/div unit, so HI/LO-dependent instructions are held in D until the result is ready.

Parameters:
- MULT_CYCLES, 5, EX-occupancy cycles of mult/multu after issue
- DIV_CYCLES, 10, EX-occupancy cycles of div/divu after issue
- CNT_W, 32, width of stall_cnt

Ports:
- clk  in  1  pipeline clock
- reset  in  1  synchronous active-high reset
- rs_d  in  5  rs field of instruction in D
- rt_d  in  5  rt field of instruction in D
- tuse_rs_d  in  2  cycles until rs needed (0,1,2); 3 = not used
- tuse_rt_d  in  2  same, for rt
- md_use_d  in  1  D instruction is mult/div/mfhi/mflo/mthi/mtlo
- rs_e  in  5  rs of instruction in E
- rt_e  in  5  rt of instruction in E
- a3_e  in  5  destination register of E instruction (0 = none)
- tnew_e  in  2  cycles until E result available
- md_start_e  in  1  E instruction is mult/div (valid one cycle)
- md_div_e  in  1  1 = div/divu, 0 = mult/multu; qualified by md_start_e
- a3_m  in  5  destination of M instruction
- tnew_m  in  2  cycles until M result available
- a3_w  in  5  destination of W instruction (tnew always 0)
- pc_en  out  1  PC load enable (1 = load)
- ifid_en  out  1  IF/ID load enable (1 = load)
- idex_flush  out  1  ID/EX clear (1 = load zeros)
- fwd_rs_d  out  2  D-stage rs mux select: 00 regfile, 01 M, 10 W
- fwd_rt_d  out  2  same, for rt
- fwd_rs_e  out  2  E-stage rs mux select: 00 ID/EX value, 01 M, 10 W
- fwd_rt_e  out  2  same, for rt
- md_busy  out  1  mult/div unit occupied
- stall_cnt  out  CNT_W  stall cycle count (see Optional Feature)

Behaviour:
- Single clock domain, clk. reset is synchronous and active-high.
- State:
  - md_cnt: width sized to hold max(MULT_CYCLES, DIV_CYCLES).
  - stall_cnt register.
  - Both clear to 0 on reset, regardless of md_start_e in the same cycle.
- md_cnt:
  - If md_start_e: load DIV_CYCLES when md_div_e = 1, else MULT_CYCLES.
  - Else if md_cnt != 0: decrement by 1.
  - Else: hold at 0.
  - md_start_e while md_cnt != 0 reloads (cannot occur in a correct pipeline; no assertion required).
- md_busy (combinational) = md_start_e | (md_cnt != 0).
  - After issue at cycle t, md_busy is high for cycles t .. t+N, where N is the loaded count.
- Data stall, evaluated for each of rs_d and rt_d as reg r with tuse:
  - Stall if r != 0, r == a3_e and tuse < tnew_e.
  - Or if r != 0, r == a3_m and tuse < tnew_m.
  - tuse = 3 never stalls.
  - The W stage never causes a stall.
- MD stall = md_use_d & md_busy.
- stall = data stall | MD stall. Outputs:
  - pc_en = ~stall
  - ifid_en = ~stall
  - idex_flush = stall (a bubble enters E)
- During the reset cycle, outputs still follow the combinational equations.
  - md_busy, however, reflects only md_start_e, since md_cnt is being cleared.
- Forwarding select, identical rule for each of the four selects (source register r):
  - r == 0 → 00.
  - Else r == a3_m and tnew_m == 0 → 01.
  - Else r == a3_w → 10.
  - Else → 00.
  - M has priority over W when both match.
  - A match with tnew_m != 0 selects W if W also matches, else 00. A stall covers that case in D. For E selects it is covered by the earlier D-stage stall.
- All outputs other than stall_cnt are purely combinational from inputs and md_cnt. Zero-cycle latency.

Optional Feature:
- Macro: HAZ_STALL_CNT_EN.
- Defined:
  - stall_cnt increments by 1 on every clk edge where stall = 1 and reset = 0.
  - Saturates at all-ones.
  - Cleared by reset.
- Undefined: no counter register is built; stall_cnt is tied to 0.

Test Plan:
- Load-use: a3_e=8, tnew_e=2, rs_d=8, tuse_rs_d=1 → pc_en=0, ifid_en=0, idex_flush=1. Next cycle a3_m=8, tnew_m=1, tuse still 1 → no stall; fwd_rs_d=00.
- Forward priority: rs_e=5, a3_m=5, tnew_m=0, a3_w=5 → fwd_rs_e=01. Change a3_m to 6 → fwd_rs_e=10. Set rs_e=0 with a3_w=0 → 00.
- Divide: pulse md_start_e=1, md_div_e=1 at cycle t. Hold md_use_d=1 → md_busy and stall high cycles t..t+10, low at t+11. Repeat with mult → low at t+6.
- Reset mid-operation: start div, assert reset at t+3 → md_cnt=0 at t+4, md_busy=0 and no stall from md_use_d.
- Register zero: rs_d=0, a3_e=0, tnew_e=2, tuse_rs_d=0 → no stall, fwd_rs_d=00.
- With HAZ_STALL_CNT_EN: 4 stall cycles after reset → stall_cnt=4. Without the macro: stall_cnt=0 throughout.
